// File: rtl/spi_pin_engine_if.sv
// Command/response handshake bundle between a host and the SPI pin engine.
interface spi_pin_engine_if;
  localparam int unsigned CMD_W = 10;
  localparam int unsigned RSP_W = 8;

  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_data;
  logic             cmd_ready;
  logic             rsp_valid;
  logic [RSP_W-1:0] rsp_data;
  logic             rsp_ready;

  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/spi_pin_engine.sv
// SPI master pin engine: CS control and byte transfers on raw pin-buffer signals.
module spi_pin_engine #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] clkdiv,
  input  logic                 cpol,
  input  logic                 cpha,
  spi_pin_engine_if.slave      bus,
  output logic                 busy,
  output logic                 mosi_dout,
  output logic                 mosi_oe,
  output logic                 sclk_dout,
  output logic                 sclk_oe,
  output logic                 cs_dout,
  output logic                 cs_oe,
  input  logic                 miso_din
);

  localparam int unsigned HIDX_W = 4;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] OP_CS_ASSERT   = 2'b00;
  localparam logic [1:0] OP_CS_DEASSERT = 2'b01;
  localparam logic [1:0] OP_XFER        = 2'b10;

  localparam logic [HIDX_W-1:0] LAST_HALF = HIDX_W'(15);

  typedef enum logic [1:0] {IDLE, CS_SET, SHIFT, RESP} state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  cpha_q, cpha_d;
  logic [HIDX_W-1:0]     hidx_q, hidx_d;
  logic [BYTE_W-1:0]     tx_q, tx_d;
  logic [BYTE_W-1:0]     rx_q, rx_d;
  logic [BYTE_W-1:0]     rsp_data_q, rsp_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  busy_q, busy_d;
  logic                  mosi_q, mosi_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_q, cs_d;
  logic                  oe_q, oe_d;
  logic                  armed_q, armed_d;

  logic [1:0]            opcode;
  logic [BYTE_W-1:0]     tx_byte;
  logic                  accept;
  logic                  sample_edge;

  assign opcode        = bus.cmd_data[9:8];
  assign tx_byte       = bus.cmd_data[7:0];
  // armed_q keeps cmd_ready low until the first cycle after reset releases
  assign bus.cmd_ready = (state_q == IDLE) && enable && !rsp_valid_q && armed_q;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = busy_q;
  assign mosi_dout     = mosi_q;
  assign sclk_dout     = sclk_q;
  assign cs_dout       = cs_q;
  assign mosi_oe       = oe_q;
  assign sclk_oe       = oe_q;
  assign cs_oe         = oe_q;

  // Next-state, shift datapath and pin levels
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    cpha_d      = cpha_q;
    hidx_d      = hidx_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    mosi_d      = mosi_q;
    sclk_d      = sclk_q;
    cs_d        = cs_q;
    oe_d        = enable;
    armed_d     = 1'b1;
    // even half-periods end on a leading edge; cpha picks which edge samples
    sample_edge = (~hidx_q[0]) ^ cpha_q;

    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (accept) begin
          div_d  = clkdiv;
          cpha_d = cpha;
          cnt_d  = clkdiv;
          case (opcode)
            OP_CS_ASSERT: begin
              cs_d    = 1'b0;
              state_d = CS_SET;
            end
            OP_CS_DEASSERT: begin
              cs_d    = 1'b1;
              state_d = CS_SET;
            end
            OP_XFER: begin
              state_d = SHIFT;
              hidx_d  = '0;
              rx_d    = '0;
              if (cpha) begin
                tx_d = tx_byte;
              end else begin
                mosi_d = tx_byte[7];
                tx_d   = {tx_byte[6:0], 1'b0};
              end
            end
            default: ;
          endcase
        end
      end

      CS_SET: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end

      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end else begin
          cnt_d  = div_q;
          hidx_d = hidx_q + HIDX_W'(1);
          sclk_d = ~sclk_q;
          if (sample_edge) begin
            rx_d = {rx_q[6:0], miso_din};
          end else begin
            mosi_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (hidx_q == LAST_HALF) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_d;
          end
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    // losing enable abandons whatever was in flight
    if (!enable) begin
      state_d     = IDLE;
      cs_d        = 1'b1;
      sclk_d      = cpol;
      rsp_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      cpha_q      <= 1'b0;
      hidx_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mosi_q      <= 1'b0;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      oe_q        <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      cpha_q      <= cpha_d;
      hidx_q      <= hidx_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      mosi_q      <= mosi_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      oe_q        <= oe_d;
      armed_q     <= armed_d;
    end
  end

endmodule

// File: tb/tb_spi_pin_engine.sv
// Directed self-checking bench for spi_pin_engine with a response scoreboard.
module tb_spi_pin_engine;
  localparam int unsigned DIV_W = 8;

  logic             clock;
  logic             reset;
  logic             enable;
  logic [DIV_W-1:0] clkdiv;
  logic             cpol;
  logic             cpha;
  logic             busy, mosi_dout, mosi_oe, sclk_dout, sclk_oe, cs_dout, cs_oe;
  logic             miso_din;
  logic             loopback;
  logic             miso_tie;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  spi_pin_engine_if bus();

  spi_pin_engine #(.DIV_WIDTH(DIV_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .clkdiv    (clkdiv),
    .cpol      (cpol),
    .cpha      (cpha),
    .bus       (bus),
    .busy      (busy),
    .mosi_dout (mosi_dout),
    .mosi_oe   (mosi_oe),
    .sclk_dout (sclk_dout),
    .sclk_oe   (sclk_oe),
    .cs_dout   (cs_dout),
    .cs_oe     (cs_oe),
    .miso_din  (miso_din)
  );

  assign miso_din = loopback ? mosi_dout : miso_tie;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for cmd_ready, presents one command for exactly one edge
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] d);
    int n;
    n = 0;
    #1;
    while (bus.cmd_ready !== 1'b1 && n < 200) begin
      tick();
      #1;
      n++;
    end
    chk_b("cmd_ready_wait", n < 200, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = {op, d};
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Runs one transfer and checks timing, SCK shape, CS and the scoreboarded byte
  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp_rx,
                      input logic [DIV_W-1:0] div, input logic pol, input logic pha,
                      input logic scramble, input string tag);
    int         cyc;
    int         pulses;
    int         first_edge;
    logic       prev;
    logic       cs_bad;
    logic [7:0] want;
    clkdiv = div;
    cpol   = pol;
    cpha   = pha;
    tick();
    chk_b({tag, "_sck_idle"}, sclk_dout, pol);
    exp_q.push_back(exp_rx);
    send_cmd(2'b10, tx);
    if (scramble) begin
      clkdiv = ~div;
      cpha   = ~pha;
    end
    if (!pha) chk_b({tag, "_mosi_first"}, mosi_dout, tx[7]);
    cyc        = 1;
    pulses     = 0;
    first_edge = 0;
    prev       = pol;
    cs_bad     = 1'b0;
    while (bus.rsp_valid !== 1'b1 && cyc < 5000) begin
      if (sclk_dout !== prev) begin
        if (first_edge == 0) first_edge = cyc;
        if (prev == pol) pulses++;
      end
      if (cs_dout !== 1'b0) cs_bad = 1'b1;
      prev = sclk_dout;
      tick();
      cyc++;
    end
    chk_w({tag, "_latency"}, cyc, 16 * (int'(div) + 1) + 1);
    chk_w({tag, "_pulses"}, pulses, 8);
    chk_w({tag, "_first_edge"}, first_edge, int'(div) + 2);
    chk_b({tag, "_cs_held"}, cs_bad, 1'b0);
    chk_b({tag, "_sck_return"}, sclk_dout, pol);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    chk_w({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(want));
    clkdiv = div;
    cpha   = pha;
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk_b("rsp_drop", bus.rsp_valid, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_b({tag, "_cmd_ready"}, bus.cmd_ready, 1'b0);
    chk_b({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk_w({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_sclk"}, sclk_dout, 1'b0);
    chk_b({tag, "_mosi"}, mosi_dout, 1'b0);
    chk_b({tag, "_cs"}, cs_dout, 1'b1);
    chk_b({tag, "_mosi_oe"}, mosi_oe, 1'b0);
    chk_b({tag, "_sclk_oe"}, sclk_oe, 1'b0);
    chk_b({tag, "_cs_oe"}, cs_oe, 1'b0);
  endtask

  initial begin
    int   busy_cnt;
    logic seen_rsp;
    reset         = 1'b1;
    enable        = 1'b1;
    clkdiv        = '0;
    cpol          = 1'b0;
    cpha          = 1'b0;
    loopback      = 1'b1;
    miso_tie      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;

    // reset state, then release
    repeat (3) tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    #1;
    chk_b("ready_at_release", bus.cmd_ready, 1'b0);
    tick();
    chk_b("ready_after_release", bus.cmd_ready, 1'b1);
    chk_b("oe_after_release", sclk_oe, 1'b1);

    // CS assert then loopback transfer, mode 0, fastest SCK
    send_cmd(2'b00, 8'h00);
    chk_b("cs_set_busy", busy, 1'b1);
    chk_b("cs_set_low", cs_dout, 1'b0);
    tick();
    chk_b("cs_set_done", busy, 1'b0);
    xfer(8'hA5, 8'hA5, 8'd0, 1'b0, 1'b0, 1'b0, "m0_a5");
    take_rsp();

    // mode 3, divider 3, MISO tied high
    loopback = 1'b0;
    miso_tie = 1'b1;
    xfer(8'h3C, 8'hFF, 8'd3, 1'b1, 1'b1, 1'b0, "m3_ff");
    take_rsp();
    miso_tie = 1'b0;
    xfer(8'hFF, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0, "m0_zero");
    take_rsp();
    loopback = 1'b1;

    // config inputs disturbed mid-transfer, other modes, largest divider
    xfer(8'h5A, 8'h5A, 8'd1, 1'b0, 1'b1, 1'b1, "m1_scramble");
    take_rsp();
    xfer(8'hC3, 8'hC3, 8'd2, 1'b1, 1'b0, 1'b0, "m2_c3");
    take_rsp();
    xfer(8'h81, 8'h81, 8'hFF, 1'b0, 1'b0, 1'b0, "m0_maxdiv");
    take_rsp();

    // response back-pressure with a pending command
    xfer(8'h96, 8'h96, 8'd0, 1'b0, 1'b0, 1'b0, "bp");
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = {2'b01, 8'h00};
    for (int i = 0; i < 20; i++) begin
      #1;
      chk_b("bp_valid", bus.rsp_valid, 1'b1);
      chk_w("bp_data", 32'(bus.rsp_data), 32'h96);
      chk_b("bp_ready", bus.cmd_ready, 1'b0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    chk_b("bp_after_valid", bus.rsp_valid, 1'b0);
    chk_b("bp_after_idle", busy, 1'b0);
    chk_b("bp_after_ready", bus.cmd_ready, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    chk_b("bp_pending_busy", busy, 1'b1);
    chk_b("bp_pending_cs", cs_dout, 1'b1);
    tick();
    chk_b("bp_pending_done", busy, 1'b0);

    // enable dropped during half-period 7
    send_cmd(2'b00, 8'h00);
    tick();
    clkdiv = 8'd1;
    cpol   = 1'b1;
    cpha   = 1'b0;
    tick();
    send_cmd(2'b10, 8'h5A);
    repeat (14) tick();
    chk_b("abort_pre_busy", busy, 1'b1);
    enable = 1'b0;
    tick();
    chk_b("abort_busy", busy, 1'b0);
    chk_b("abort_cs", cs_dout, 1'b1);
    chk_b("abort_sclk", sclk_dout, 1'b1);
    chk_b("abort_rsp", bus.rsp_valid, 1'b0);
    chk_b("abort_oe", mosi_oe, 1'b0);
    chk_b("abort_ready", bus.cmd_ready, 1'b0);
    seen_rsp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid === 1'b1) seen_rsp = 1'b1;
      tick();
    end
    chk_b("abort_no_rsp", seen_rsp, 1'b0);
    enable = 1'b1;
    tick();
    #1;
    chk_b("reenable_ready", bus.cmd_ready, 1'b1);
    chk_b("reenable_oe", cs_oe, 1'b1);

    // reset pulse in the middle of a transfer
    clkdiv = 8'd0;
    cpol   = 1'b0;
    send_cmd(2'b00, 8'h00);
    tick();
    send_cmd(2'b10, 8'hF0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk_reset_vals("midrst");
    reset = 1'b0;
    tick();
    send_cmd(2'b00, 8'h00);
    tick();
    xfer(8'h69, 8'h69, 8'd0, 1'b0, 1'b0, 1'b0, "post_rst");
    take_rsp();

    // reserved opcode then CS deassert back-to-back
    clkdiv = 8'd2;
    send_cmd(2'b11, 8'h00);
    chk_b("op11_busy", busy, 1'b0);
    chk_b("op11_ready", bus.cmd_ready, 1'b1);
    chk_b("op11_cs", cs_dout, 1'b0);
    send_cmd(2'b01, 8'h00);
    busy_cnt = 0;
    seen_rsp = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (bus.rsp_valid === 1'b1) seen_rsp = 1'b1;
      if (i == 3) chk_b("op01_cs_at_div", cs_dout, 1'b1);
      tick();
    end
    chk_w("op01_busy_cycles", busy_cnt, 3);
    chk_b("op01_no_rsp", seen_rsp, 1'b0);
    chk_b("op01_cs_end", cs_dout, 1'b1);

    chk_w("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
